// File: rtl/mem_port_arbiter_pkg.sv
// Shared processor definitions: FSM state encoding and owner codes
// used by the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    // Gray-coded so it lines up with the control unit's encoding
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b11,
        RESP  = 2'b10
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int CNT_W = 4;
    localparam int LAT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between fetch, data access, the arbiter
// and the single-port memory macro.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_ack, if_rdata,
        output dm_ack, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_ack, if_rdata,
        input  dm_ack, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Priority decision between fetch and data requests, with a saturating
// counter that forces a fetch grant after a run of data grants.
module arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   sample,
    input  logic   if_req,
    input  logic   dm_req,
    output logic   grant,
    output owner_t owner
);
    localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] count;
    logic             starve;
    logic             pick_dm;
    logic             pick_if;

    always_comb begin
        starve  = (count == SMAX) && if_req;
        pick_dm = dm_req && !starve;
        pick_if = if_req && !pick_dm;
        grant   = pick_dm || pick_if;
        owner   = pick_dm ? OWN_DM : OWN_IF;
    end

    // only DM grants that overtake a waiting fetch count towards starvation
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (sample) begin
            if (pick_if) begin
                count <= '0;
            end else if (pick_dm && if_req && count != SMAX) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto the single-port memory and
// returns read data with a one-cycle acknowledge to the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [LAT_W-1:0] LAT = LAT_W'(MEM_LAT);

    state_t           state_q, state_d;
    owner_t           own_q, own_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [LAT_W-1:0] lat_q, lat_d;

    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic             if_ack_q, if_ack_d;
    logic             dm_ack_q, dm_ack_d;
    logic [DW-1:0]    if_rdata_q, if_rdata_d;
    logic [DW-1:0]    dm_rdata_q, dm_rdata_d;
    logic             busy_q, busy_d;

    logic             grant;
    owner_t           pick_own;

    arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk   (clk),
        .rst   (rst),
        .sample(state_q == IDLE),
        .if_req(bus.if_req),
        .dm_req(bus.dm_req),
        .grant (grant),
        .owner (pick_own)
    );

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lat_d      = lat_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                    own_d   = pick_own;
                    if (pick_own == OWN_DM) begin
                        we_d    = bus.dm_we;
                        addr_d  = bus.dm_addr;
                        wdata_d = bus.dm_wdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = bus.if_addr;
                        wdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                lat_d   = LAT_W'(1);
                state_d = we_q ? RESP : WAIT;
            end
            WAIT: begin
                if (lat_q == LAT) begin
                    state_d = RESP;
                    if (own_q == OWN_DM) dm_rdata_d = bus.mem_rdata;
                    else if_rdata_d = bus.mem_rdata;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase

        // outputs are registered copies of what the next state implies
        mem_en_d    = (state_d == ISSUE);
        mem_we_d    = mem_en_d && we_d;
        mem_addr_d  = mem_en_d ? addr_d : '0;
        mem_wdata_d = mem_en_d ? wdata_d : '0;
        dm_ack_d    = (state_d == RESP) && (own_d == OWN_DM);
        if_ack_d    = (state_d == RESP) && (own_d == OWN_IF);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            own_q       <= OWN_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat_q       <= lat_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=1 instance for the
// vector table and corner cases, and a MEM_LAT=3 instance for latency.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(16), .DW(16)) b1 ();
    mem_port_arbiter_if #(.AW(16), .DW(16)) b3 ();

    mem_port_arbiter #(
        .AW(16), .DW(16), .MEM_LAT(1), .STARVE_MAX(4)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    mem_port_arbiter #(
        .AW(16), .DW(16), .MEM_LAT(3), .STARVE_MAX(4)
    ) dut3 (
        .clk(clk), .rst(rst), .bus(b3)
    );

    // latency-1 memory: word visible only in the cycle after MEM_EN
    logic [15:0] mem1 [256];
    logic [15:0] p1;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem1[i] <= {8'h5A, 8'(i)};
            mem1[16] <= 16'hBEEF;
            p1 <= 16'hDEAD;
        end else begin
            if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[7:0]] <= b1.mem_wdata;
            p1 <= b1.mem_en ? mem1[b1.mem_addr[7:0]] : 16'hDEAD;
        end
    end
    assign b1.mem_rdata = p1;

    // latency-3 memory: word = addr ^ C3C3, valid only 3 cycles after MEM_EN
    logic [15:0] q0, q1, q2;
    always @(posedge clk) begin
        q0 <= b3.mem_en ? (b3.mem_addr ^ 16'hC3C3) : 16'hDEAD;
        q1 <= q0;
        q2 <= q1;
    end
    assign b3.mem_rdata = q2;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic acc1(input bit is_dm, input bit we,
                        input logic [15:0] addr, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd,
                        output int ens, output int xack,
                        output logic [15:0] a1, output logic w1,
                        output logic [15:0] d1);
        lat  = 99;
        rd   = '0;
        ens  = 0;
        xack = 0;
        a1   = '0;
        w1   = 1'b0;
        d1   = '0;
        @(negedge clk);
        if (is_dm) begin
            b1.dm_req   = 1'b1;
            b1.dm_we    = we;
            b1.dm_addr  = addr;
            b1.dm_wdata = wd;
        end else begin
            b1.if_req  = 1'b1;
            b1.if_addr = addr;
        end
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (b1.mem_en) ens++;
            if (k == 1) begin
                a1 = b1.mem_addr;
                w1 = b1.mem_we;
                d1 = b1.mem_wdata;
            end
            if (is_dm ? b1.if_ack : b1.dm_ack) xack++;
            if (is_dm ? b1.dm_ack : b1.if_ack) begin
                lat = k;
                rd  = is_dm ? b1.dm_rdata : b1.if_rdata;
                break;
            end
        end
        b1.dm_req = 1'b0;
        b1.if_req = 1'b0;
    endtask

    typedef struct {
        bit          dm;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] rd;
        int          lat;
    } vec_t;

    vec_t vt [9];
    bit   exp_ord [10];

    initial begin
        int          lat, ens, xack, n, cyc, both, badaddr;
        logic [15:0] rd, a1, d1;
        logic        w1;

        b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0;
        b1.dm_addr = 0; b1.dm_wdata = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0;
        b3.dm_addr = 0; b3.dm_wdata = 0;

        vt[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3};
        vt[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'hBEEF, 2};
        vt[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 3};
        vt[3] = '{1'b1, 1'b1, 16'h0031, 16'hFFFF, 16'h1234, 2};
        vt[4] = '{1'b1, 1'b0, 16'h0031, 16'h0000, 16'hFFFF, 3};
        vt[5] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h5A05, 3};
        vt[6] = '{1'b1, 1'b1, 16'h0000, 16'h0001, 16'h5A05, 2};
        vt[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001, 3};
        vt[8] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'h5A05, 3};
        exp_ord = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        repeat (3) @(negedge clk);
        chk("rst_busy", b1.busy, 0);
        chk("rst_mem_en", b1.mem_en, 0);
        chk("rst_acks", {b1.if_ack, b1.dm_ack}, 0);
        chk("rst_rdata", {b1.if_rdata, b1.dm_rdata}, 0);
        chk("rst_mem_bus", {b1.mem_we, b1.mem_addr, b1.mem_wdata}, 0);
        chk("rst_cnt", dut1.u_pick.count, 0);
        chk("rst3_busy", b3.busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            acc1(vt[i].dm, vt[i].we, vt[i].addr, vt[i].wd,
                 lat, rd, ens, xack, a1, w1, d1);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].rd);
            chk($sformatf("v%0d_en_once", i), ens, 1);
            chk($sformatf("v%0d_other_ack", i), xack, 0);
            chk($sformatf("v%0d_mem_addr", i), a1, vt[i].addr);
            chk($sformatf("v%0d_mem_we", i), w1, vt[i].we);
            if (vt[i].we) chk($sformatf("v%0d_mem_wdata", i), d1, vt[i].wd);
        end
        chk("dm_only_cnt", dut1.u_pick.count, 0);

        // both requesters held: DM x4 then IF forced, twice
        n = 0; cyc = 0; both = 0;
        @(negedge clk);
        b1.dm_req = 1; b1.dm_we = 0; b1.dm_addr = 16'h0010;
        b1.if_req = 1; b1.if_addr = 16'h0005;
        while (n < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (b1.if_ack && b1.dm_ack) both++;
            if (b1.dm_ack || b1.if_ack) begin
                chk($sformatf("grant%0d_is_dm", n), b1.dm_ack, exp_ord[n]);
                if (b1.if_ack) chk("starve_if_rdata", b1.if_rdata, 16'h5A05);
                else chk("starve_dm_rdata", b1.dm_rdata, 16'hBEEF);
                n++;
            end
        end
        b1.dm_req = 0; b1.if_req = 0;
        chk("starve_grants", n, 10);
        chk("starve_both_ack", both, 0);
        chk("starve_cnt_after_if", dut1.u_pick.count, 0);

        // reset while in WAIT with a fetch pending
        @(negedge clk);
        b1.dm_req = 1; b1.dm_we = 0; b1.dm_addr = 16'h0010;
        b1.if_req = 1; b1.if_addr = 16'h0005;
        @(negedge clk);
        chk("rw_issue_en", b1.mem_en, 1);
        @(negedge clk);
        chk("rw_wait_busy", b1.busy, 1);
        chk("rw_cnt_before", dut1.u_pick.count, 1);
        rst = 1; b1.dm_req = 0; b1.if_req = 0;
        @(negedge clk);
        chk("rw_busy", b1.busy, 0);
        chk("rw_acks", {b1.if_ack, b1.dm_ack}, 0);
        chk("rw_mem_en", b1.mem_en, 0);
        chk("rw_cnt", dut1.u_pick.count, 0);
        chk("rw_dm_rdata", b1.dm_rdata, 0);
        rst = 0;
        acc1(1'b0, 1'b0, 16'h0005, 16'h0, lat, rd, ens, xack, a1, w1, d1);
        chk("rw_if_lat", lat, 3);
        chk("rw_if_rdata", rd, 16'h5A05);
        chk("rw_if_en_once", ens, 1);

        // MEM_LAT=3 load with the address changed mid-access
        lat = 99; ens = 0; badaddr = 0; rd = '0;
        @(negedge clk);
        b3.dm_req = 1; b3.dm_we = 0; b3.dm_addr = 16'h0040;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (b3.mem_en) begin
                ens++;
                if (b3.mem_addr != 16'h0040) badaddr++;
            end
            if (k == 1) chk("l3_en_t1", b3.mem_en, 1);
            if (k == 2) b3.dm_addr = 16'h0077;
            if (b3.dm_ack) begin
                lat = k;
                rd  = b3.dm_rdata;
                break;
            end
        end
        b3.dm_req = 0;
        chk("l3_lat", lat, 5);
        chk("l3_rdata", rd, 16'hC383);
        chk("l3_en_once", ens, 1);
        chk("l3_latched_addr", badaddr, 0);
        chk("l3_if_ack", b3.if_ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
